midi_tx_uart: RTL
=================

MIDI_TX_UART -- requirements
Module: midi_tx_uart

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI line rate; DIV = CLK_HZ/BAUD (integer, 1600 at defaults).
REQ-003 SHALL have port clk, input, 1, rising-edge system clock.
REQ-004 SHALL have port reset_reg_N, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port tx_active, input, 1, byte stream pending from the sysex dump source.
REQ-006 SHALL have port midi_out_data, input, 8, current byte from source; source updates it on the falling edge of midi_out_ready.
REQ-007 SHALL have port midi_out_ready, output, 1, fetch strobe; falling edge requests the next byte.
REQ-008 SHALL have port midi_txd, output, 1, serial MIDI line, idle high.
REQ-009 SHALL have port tx_busy, output, 1, high while a frame is on the line.

Function
REQ-010 SHALL implement states IDLE, LOAD, START, DATA, STOP.
REQ-011 IDLE: if tx_active=1, SHALL go to LOAD next cycle; else stay.
REQ-012 LOAD (1 cycle): SHALL sample midi_out_data into shift register and drive midi_out_ready low for exactly 2 clk cycles starting this cycle.
REQ-013 LOAD with sampled byte 8'hFF (idle marker): SHALL NOT transmit; SHALL return to IDLE; ready pulse still issued.
REQ-014 START: midi_txd=0 for DIV cycles; DATA: 8 bits LSB first, DIV cycles each; STOP: midi_txd=1 for DIV cycles, then IDLE.
REQ-015 Latency: first START cycle SHALL be the cycle after LOAD; back-to-back byte period SHALL be exactly 10*DIV+2 cycles (LOAD + frame + IDLE).
REQ-016 midi_out_data SHALL NOT be resampled until the next LOAD (≥10*DIV cycles after ready fall, satisfying source settle).
REQ-017 tx_active deasserting mid-frame SHALL NOT abort the frame; no new LOAD occurs.
REQ-018 Baud counter SHALL count 0..DIV-1 and wrap; bit counter 0..7; both clear on LOAD.
REQ-019 tx_busy SHALL be high in START, DATA, STOP only.

Reset
REQ-020 On reset_reg_N=0 SHALL asynchronously force: state IDLE, midi_txd=1, midi_out_ready=1, tx_busy=0, counters 0, running-status register 8'h00.
REQ-021 Reset mid-frame SHALL truncate the frame immediately; line returns high; no ready pulse after release until tx_active seen in IDLE.

Configuration
REQ-022 Macro MIDI_TX_RUNNING_STATUS_EN defined: a sampled status byte 8'h80-8'hEF equal to the last transmitted status SHALL be skipped like 8'hFF; bytes 8'hF0-8'hF7 SHALL clear the stored status; 8'hF8-8'hFE SHALL not affect it.
REQ-023 Macro undefined: every byte except 8'hFF SHALL be transmitted; no status register exists.

Structure
REQ-024 Package midi_pkg SHALL hold MIDI_BAUD, SYX_START 8'hF0, SYX_EDU_ID 8'h7D, SYX_END 8'hF7, IDLE_MARK 8'hFF and the state enum type.
REQ-025 Sub-module midi_baud_gen SHALL provide the DIV tick counter with synchronous clear.

Verification
REQ-026 tx_active=1, midi_out_data=8'hF0 -> line 0,0,0,0,0,1,1,1,1,1 (start, LSB-first, stop), each DIV cycles; ready low 2 cycles at LOAD.
REQ-027 Source model emits F0,7D,70,40 bytes,F7,FF, driving tx_active low after FF -> exactly 5 frames (F0,7D,70,40,F7) plus data bytes transmitted, FF never on line, 10*DIV+2 period.
REQ-028 tx_active dropped at mid-DATA of byte 8'h55 -> frame completes, midi_txd idle high, no further LOAD.
REQ-029 reset_reg_N pulsed low during bit 3 -> midi_txd=1, midi_out_ready=1, tx_busy=0 within same cycle; next frame starts cleanly after tx_active.
REQ-030 With MIDI_TX_RUNNING_STATUS_EN: bytes 90,3C,40,90,3E,40 -> line carries 90,3C,40,3E,40; insert F0 then 90 -> 90 retransmitted.
REQ-031 CLK_HZ=1_000_000 -> DIV=32; verify bit width 32 cycles and period 322 cycles.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM state type and byte-class helpers for the MIDI transmitter.
package midi_pkg;

  localparam int unsigned MIDI_BAUD  = 31250;
  localparam logic [7:0]  SYX_START  = 8'hF0;
  localparam logic [7:0]  SYX_EDU_ID = 8'h7D;
  localparam logic [7:0]  SYX_END    = 8'hF7;
  localparam logic [7:0]  IDLE_MARK  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } midi_state_e;

  // Channel voice/mode status bytes are the ones eligible for running status.
  function automatic logic is_channel_status(input logic [7:0] b);
    return (b >= 8'h80) && (b <= 8'hEF);
  endfunction

  function automatic logic is_system_common(input logic [7:0] b);
    return (b >= SYX_START) && (b <= SYX_END);
  endfunction

endpackage

// File: rtl/midi_baud_gen.sv
// Bit-period tick generator: counts 0..DIV-1 and flags the last cycle of each period.
module midi_baud_gen #(
  parameter int unsigned DIV = 1600
) (
  input  logic clk_i,
  input  logic reset_reg_N,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and a tick that is registered yet still coincides with cnt_q == LAST.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = !clr_i && (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk_i or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/midi_tx_uart.sv
// MIDI 8N1 serial transmitter fed by a byte source through a falling-edge fetch strobe.
// Optional running-status suppression: define MIDI_TX_RUNNING_STATUS_EN.
module midi_tx_uart
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = MIDI_BAUD
) (
  input  logic       clk,
  input  logic       reset_reg_N,
  input  logic       tx_active,
  input  logic [7:0] midi_out_data,
  output logic       midi_out_ready,
  output logic       midi_txd,
  output logic       tx_busy
);

  localparam int unsigned DIV = CLK_HZ / BAUD;

  midi_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_q;
  logic        ready_q;
  logic        ready_hold_q;
  logic        txd_q;
  logic        busy_q;
  logic        skip_s;
  logic        baud_clr_s;
  logic        baud_tick_s;

  assign baud_clr_s = (state_q == LOAD);

  midi_baud_gen #(.DIV(DIV)) u_baud (
    .clk_i       (clk),
    .reset_reg_N (reset_reg_N),
    .clr_i       (baud_clr_s),
    .tick_o      (baud_tick_s)
  );

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] status_q;

  assign skip_s = (shift_q == IDLE_MARK) ||
                  (is_channel_status(shift_q) && (shift_q == status_q));

  // Running-status register: follows transmitted channel status, cleared by system common.
  always_ff @(posedge clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      status_q <= 8'h00;
    end else if ((state_q == LOAD) && !skip_s) begin
      if (is_channel_status(shift_q)) begin
        status_q <= shift_q;
      end else if (is_system_common(shift_q)) begin
        status_q <= 8'h00;
      end else begin
        status_q <= status_q;
      end
    end else begin
      status_q <= status_q;
    end
  end
`else
  assign skip_s = (shift_q == IDLE_MARK);
`endif

  // Frame FSM; the byte is captured on the edge entering LOAD, before the source
  // reacts to the ready fall. IDLE waits for ready to recover so that a skipped
  // byte still leaves a distinct falling edge for the following fetch.
  always_ff @(posedge clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_q        <= 3'd0;
      ready_q      <= 1'b1;
      ready_hold_q <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      ready_q      <= ~ready_hold_q;
      ready_hold_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_active && ready_q) begin
            state_q      <= LOAD;
            shift_q      <= midi_out_data;
            bit_q        <= 3'd0;
            ready_q      <= 1'b0;
            ready_hold_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          bit_q <= 3'd0;
          if (skip_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_tick_s) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            state_q <= START;
          end
        end
        DATA: begin
          if (baud_tick_s) begin
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            state_q <= DATA;
          end
        end
        STOP: begin
          if (baud_tick_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= STOP;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign midi_out_ready = ready_q;
  assign midi_txd       = txd_q;
  assign tx_busy        = busy_q;

endmodule
